// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl
//   Mode and time-set sequencer for the wristwatch. It decodes debounced
//   button pulses into a four-state mode machine (CLOCK / STOPWATCH / SET_HR /
//   SET_MIN). It drives the stopwatch run/clear controls and issues hour/minute
//   increment pulses, with auto-repeat while the increment button is held. It
//   also produces a digit-blink mask for the field being set.
//
// Ports
//   i_uclock       system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_mode_down    one-cycle pulse, mode button
//   i_set_down     one-cycle pulse, set/clear button
//   i_inc_down     one-cycle pulse, increment button
//   i_inc_held     debounced level of the increment button
//   i_start_down   one-cycle pulse, start/stop button
//   o_disp_sel     0 = time-of-day digits, 1 = stopwatch digits
//   o_sw_run       stopwatch count enable
//   o_sw_clear     one-cycle pulse, zero the stopwatch
//   o_hr_inc       one-cycle pulse, advance hours
//   o_min_inc      one-cycle pulse, advance minutes
//   o_clk_hold     freeze time-of-day counting while setting
//   o_blank[3:0]   per-digit blanking mask
//   o_mode[1:0]    0 CLOCK, 1 STOPWATCH, 2 SET_HR, 3 SET_MIN
module watch_mode_ctrl #(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int TIMEOUT      = 500_000_000,
  parameter int BLINK_HALF   = 12_500_000,
  parameter int CNT_W        = 29
) (
  input  logic       i_uclock,
  input  logic       i_reset,
  input  logic       i_mode_down,
  input  logic       i_set_down,
  input  logic       i_inc_down,
  input  logic       i_inc_held,
  input  logic       i_start_down,
  output logic       o_disp_sel,
  output logic       o_sw_run,
  output logic       o_sw_clear,
  output logic       o_hr_inc,
  output logic       o_min_inc,
  output logic       o_clk_hold,
  output logic [3:0] o_blank,
  output logic [1:0] o_mode
);

  localparam logic [1:0] S_CLOCK   = 2'd0;
  localparam logic [1:0] S_SW      = 2'd1;
  localparam logic [1:0] S_SET_HR  = 2'd2;
  localparam logic [1:0] S_SET_MIN = 2'd3;

  localparam logic [CNT_W-1:0] L_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_RD   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] L_RR   = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] L_TO   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_BH   = CNT_W'(BLINK_HALF - 1);

  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic             r_rep_act, w_rep_act_nxt;
  logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;
  logic [CNT_W-1:0] r_blk_cnt, w_blk_cnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic             w_inc_fire;
  logic [3:0]       w_blank_nxt;
  logic             w_run_nxt;
  logic             w_clear_nxt;

  // One honoured event per cycle: mode > set > inc > start.
  logic w_ev_mode, w_ev_set, w_ev_inc, w_ev_start, w_any_down;
  assign w_ev_mode  = i_mode_down;
  assign w_ev_set   = i_set_down & ~i_mode_down;
  assign w_ev_inc   = i_inc_down & ~i_mode_down & ~i_set_down;
  assign w_ev_start = i_start_down & ~i_mode_down & ~i_set_down & ~i_inc_down;
  assign w_any_down = i_mode_down | i_set_down | i_inc_down | i_start_down;

  logic w_in_set, w_nxt_set, w_stay_set, w_entry, w_timeout;
  assign w_in_set   = r_mode[1];
  assign w_nxt_set  = w_mode_nxt[1];
  assign w_stay_set = w_in_set & (w_mode_nxt == r_mode);
  assign w_entry    = w_nxt_set & (w_mode_nxt != r_mode);
  // Any activity this cycle restarts the idle count instead of timing out.
  assign w_timeout  = w_in_set & (r_to_cnt == L_TO) & ~w_any_down & ~i_inc_held;

  assign o_mode = r_mode;

  // State register
  always_ff @(posedge i_uclock) begin
    if (i_reset) begin
      r_mode <= S_CLOCK;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      S_CLOCK: begin
        if (w_ev_mode)     w_mode_nxt = S_SW;
        else if (w_ev_set) w_mode_nxt = S_SET_HR;
        else               w_mode_nxt = S_CLOCK;
      end
      S_SW: begin
        if (w_ev_mode) w_mode_nxt = S_CLOCK;
        else           w_mode_nxt = S_SW;
      end
      S_SET_HR: begin
        if (w_ev_mode)      w_mode_nxt = S_CLOCK;
        else if (w_ev_set)  w_mode_nxt = S_SET_MIN;
        else if (w_timeout) w_mode_nxt = S_CLOCK;
        else                w_mode_nxt = S_SET_HR;
      end
      S_SET_MIN: begin
        if (w_ev_mode | w_ev_set | w_timeout) w_mode_nxt = S_CLOCK;
        else                                  w_mode_nxt = S_SET_MIN;
      end
      default: w_mode_nxt = S_CLOCK;
    endcase
  end

  // Output / counter next values
  always_comb begin
    w_inc_fire    = 1'b0;
    w_rep_cnt_nxt = r_rep_cnt;
    w_rep_act_nxt = r_rep_act;
    // Auto-repeat: a state change always cancels, so a repeat tick never
    // lands in the state being left.
    if (!w_stay_set) begin
      w_rep_cnt_nxt = L_ZERO;
      w_rep_act_nxt = 1'b0;
    end else if (w_ev_inc) begin
      w_inc_fire    = 1'b1;
      w_rep_cnt_nxt = L_RD;
      w_rep_act_nxt = 1'b1;
    end else if (!i_inc_held) begin
      w_rep_cnt_nxt = L_ZERO;
      w_rep_act_nxt = 1'b0;
    end else if (r_rep_act) begin
      if (r_rep_cnt == L_ZERO) begin
        w_inc_fire    = 1'b1;
        w_rep_cnt_nxt = L_RR;
      end else begin
        w_rep_cnt_nxt = r_rep_cnt - L_ONE;
      end
    end else begin
      w_rep_cnt_nxt = r_rep_cnt;
    end

    // Idle timeout counter saturates at TIMEOUT-1.
    if (!w_nxt_set) begin
      w_to_cnt_nxt = L_ZERO;
    end else if (w_entry | w_any_down | i_inc_held) begin
      w_to_cnt_nxt = L_ZERO;
    end else if (r_to_cnt != L_TO) begin
      w_to_cnt_nxt = r_to_cnt + L_ONE;
    end else begin
      w_to_cnt_nxt = r_to_cnt;
    end

    // Blink restarts visible on entry and on each increment for feedback.
    if (!w_nxt_set) begin
      w_blk_cnt_nxt = L_ZERO;
      w_phase_nxt   = 1'b0;
    end else if (w_entry | w_inc_fire) begin
      w_blk_cnt_nxt = L_ZERO;
      w_phase_nxt   = 1'b0;
    end else if (r_blk_cnt == L_BH) begin
      w_blk_cnt_nxt = L_ZERO;
      w_phase_nxt   = ~r_phase;
    end else begin
      w_blk_cnt_nxt = r_blk_cnt + L_ONE;
      w_phase_nxt   = r_phase;
    end

    case (w_mode_nxt)
      S_SET_HR:  w_blank_nxt = {w_phase_nxt, w_phase_nxt, 2'b00};
      S_SET_MIN: w_blank_nxt = {2'b00, w_phase_nxt, w_phase_nxt};
      default:   w_blank_nxt = 4'b0000;
    endcase

    w_run_nxt   = r_sw_run_toggle();
    w_clear_nxt = w_ev_set & (r_mode == S_SW) & ~o_sw_run;
  end

  function automatic logic r_sw_run_toggle();
    return o_sw_run ^ (w_ev_start & (r_mode == S_SW));
  endfunction

  // Registered outputs and counters
  always_ff @(posedge i_uclock) begin
    if (i_reset) begin
      r_rep_cnt  <= L_ZERO;
      r_rep_act  <= 1'b0;
      r_to_cnt   <= L_ZERO;
      r_blk_cnt  <= L_ZERO;
      r_phase    <= 1'b0;
      o_disp_sel <= 1'b0;
      o_sw_run   <= 1'b0;
      o_sw_clear <= 1'b0;
      o_hr_inc   <= 1'b0;
      o_min_inc  <= 1'b0;
      o_clk_hold <= 1'b0;
      o_blank    <= 4'b0000;
    end else begin
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_rep_act  <= w_rep_act_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_blk_cnt  <= w_blk_cnt_nxt;
      r_phase    <= w_phase_nxt;
      o_disp_sel <= (w_mode_nxt == S_SW);
      o_sw_run   <= w_run_nxt;
      o_sw_clear <= w_clear_nxt;
      o_hr_inc   <= w_inc_fire & (r_mode == S_SET_HR);
      o_min_inc  <= w_inc_fire & (r_mode == S_SET_MIN);
      o_clk_hold <= w_nxt_set;
      o_blank    <= w_blank_nxt;
    end
  end

endmodule

// File: doc/watch_mode_ctrl.md
# watch_mode_ctrl

Mode and time-set sequencer for the wristwatch top level. It consumes the one-cycle press pulses and held levels from the four push-button debouncers. It selects whether the display mux shows the time-of-day or the stopwatch, and owns the stopwatch run/clear controls. It also walks the user through setting hours and minutes, issuing increment pulses to the clock counter and a digit-blink mask to the display path.

## Interface
- REPEAT_DELAY, 25_000_000: cycles an increment button must be held before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_RATE, 5_000_000: cycles between auto-repeat increments.
- TIMEOUT, 500_000_000: idle cycles in a set state before returning to clock mode.
- BLINK_HALF, 12_500_000: cycles per blink half-period.
- CNT_W, 29: width of the internal counters; must hold TIMEOUT-1.

- uclock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mode_down  in  1  one-cycle pulse, mode button pressed (buttons[0]).
- set_down  in  1  one-cycle pulse, set/clear button pressed (buttons[1]).
- inc_down  in  1  one-cycle pulse, increment button pressed (buttons[2]).
- inc_held  in  1  debounced level of the increment button.
- start_down  in  1  one-cycle pulse, start/stop button pressed (buttons[3]).
- disp_sel  out  1  0 = time-of-day digits, 1 = stopwatch digits.
- sw_run  out  1  stopwatch count enable.
- sw_clear  out  1  one-cycle pulse, zero the stopwatch.
- hr_inc  out  1  one-cycle pulse, advance hours by one.
- min_inc  out  1  one-cycle pulse, advance minutes by one.
- clk_hold  out  1  freezes time-of-day counting while setting.
- blank  out  4  per-digit blanking mask; bit n blanks anode n.
- mode  out  2  current state: 0 CLOCK, 1 STOPWATCH, 2 SET_HR, 3 SET_MIN.

## Operation
- FSM states and transitions:
  - CLOCK: mode_down goes to STOPWATCH; set_down goes to SET_HR.
  - STOPWATCH: mode_down goes to CLOCK. start_down toggles sw_run. set_down pulses sw_clear only when sw_run=0; it is ignored while running.
  - SET_HR: inc event pulses hr_inc. set_down goes to SET_MIN. mode_down goes to CLOCK. Timeout goes to CLOCK.
  - SET_MIN: inc event pulses min_inc. set_down goes to CLOCK. mode_down goes to CLOCK. Timeout goes to CLOCK.
- Only one input event is acted on per cycle. Priority is mode_down > set_down > inc_down > start_down; lower-priority pulses in the same cycle are dropped.
- start_down is honoured only in STOPWATCH.
- sw_run persists across all mode changes, so the stopwatch keeps running in the background. Only start_down or reset changes it.
- disp_sel = 1 only in STOPWATCH.
- clk_hold = 1 in SET_HR and SET_MIN.
- Auto-repeat in set states:
  - inc_down gives an immediate increment and loads the repeat counter with REPEAT_DELAY-1.
  - While inc_held=1, the counter decrements. At 0 it fires an increment and reloads REPEAT_RATE-1.
  - inc_held=0 or leaving the set state clears the counter and stops repeat.
- Timeout counter:
  - Cleared on entry to a set state, on any *_down pulse, and on every cycle inc_held=1.
  - Otherwise it increments in set states.
  - When it reaches TIMEOUT-1, the FSM moves to CLOCK on the next edge.
  - The counter is held at 0 outside set states.
- Blink:
  - A phase bit toggles every BLINK_HALF cycles.
  - The phase and its counter reset to 0 (digits visible) on entry to a set state and on every increment pulse.
  - SET_HR: blank = {p,p,0,0}. SET_MIN: blank = {0,0,p,p}. Other states: blank = 0.

## Timing
- All outputs are registered. A response appears on the first edge after the input pulse is sampled (1-cycle latency).
- Each hr_inc, min_inc and sw_clear pulse is exactly 1 cycle wide.
- Auto-repeat spacing:
  - First repeat pulse: REPEAT_DELAY cycles after the inc_down-driven pulse.
  - Subsequent repeat pulses: every REPEAT_RATE cycles.
- Reset values: mode=0 (CLOCK), disp_sel=0, sw_run=0, sw_clear=0, hr_inc=0, min_inc=0, clk_hold=0, blank=4'b0000. All counters are 0.
- Reset mid-set or mid-repeat returns to CLOCK the next cycle with no increment pulse. A reset asserted in the same cycle as any *_down takes precedence.
- Counters saturate and never wrap; the timeout cannot re-fire until cleared.

## Test plan
Directed bench parameters: REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT=50, BLINK_HALF=5.
- Reset, then mode_down: mode=1 and disp_sel=1 one cycle later. Then start_down: sw_run=1. Then mode_down: mode=0, sw_run still 1.
- STOPWATCH with sw_run=1, set_down: no sw_clear. Then start_down, then set_down: sw_clear high for exactly 1 cycle, sw_run=0.
- CLOCK, set_down: mode=2, clk_hold=1. Then inc_down with inc_held high for 20 cycles: hr_inc pulses at t+1, t+9, t+13, t+17, and none after release.
- SET_MIN, idle for 50 cycles: mode returns to 0 and clk_hold=0. Any press at cycle 30 restarts the 50-cycle count.
- Same-cycle mode_down and inc_down in SET_HR: mode=0, no hr_inc. In SET_MIN, blank toggles {0,0,1,1}/0000 every 5 cycles, starting visible.
